// File: rtl/sdram_test_sequencer.sv
// ---------------------------------------------------------------------------
// sdram_test_sequencer
//
// Push-button driven SDRAM write/read-back tester. Each accepted button press
// bumps an 8-bit seed, writes N_WORDS words of pattern {seed, index} starting
// at BASE_ADDR, then reads them back one at a time and counts mismatches.
// The result is shown on the LEDs as {pass, fail, err_count[5:0]}.
//
// Ports
//   CLOCK_100  in   1   sole clock, rising edge
//   rst        in   1   synchronous reset, active-high
//   button     in   1   raw asynchronous push-button, active-high
//   cmd_valid  out  1   command request to the SDRAM driver
//   cmd_we     out  1   1 = write, 0 = read
//   cmd_addr   out  24  word address
//   cmd_wdata  out  16  write data (0 for reads)
//   cmd_ready  in   1   driver accepts the command this cycle
//   rd_valid   in   1   read data present this cycle
//   rd_data    in   16  read data
//   busy       out  1   high while a run is in progress
//   led        out  8   {pass, fail, err_count[5:0]}
// ---------------------------------------------------------------------------
module sdram_test_sequencer #(
  parameter int          N_WORDS         = 16,
  parameter int          DEBOUNCE_CYCLES = 4,
  parameter logic [23:0] BASE_ADDR       = 24'h000000
) (
  input  logic        CLOCK_100,
  input  logic        rst,
  input  logic        button,
  output logic        cmd_valid,
  output logic        cmd_we,
  output logic [23:0] cmd_addr,
  output logic [15:0] cmd_wdata,
  input  logic        cmd_ready,
  input  logic        rd_valid,
  input  logic [15:0] rd_data,
  output logic        busy,
  output logic [7:0]  led
);

  // -------------------------------------------------------------------------
  // Constants
  // -------------------------------------------------------------------------
  localparam int DB_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0]      LAST_INDEX = 8'(N_WORDS - 1);
  localparam logic [5:0]      ERR_MAX    = 6'd63;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WRITE   = 3'd1;
  localparam logic [2:0] S_READ    = 3'd2;
  localparam logic [2:0] S_WAIT_RD = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  // -------------------------------------------------------------------------
  // Button synchronizer, debouncer and start-pulse generator
  // -------------------------------------------------------------------------
  logic            btn_meta_reg;
  logic            btn_sync_reg;
  logic            db_level_reg;
  logic            db_level_next;
  logic [DB_W-1:0] db_count_reg;
  logic [DB_W-1:0] db_count_next;
  logic            start_pulse_reg;

  always_ff @(posedge CLOCK_100) begin
    if (rst) begin
      btn_meta_reg <= 1'b0;
      btn_sync_reg <= 1'b0;
    end else begin
      btn_meta_reg <= button;
      btn_sync_reg <= btn_meta_reg;
    end
  end

  // The count only advances while the synchronized input disagrees with the
  // accepted level; any agreeing sample throws the partial count away.
  always_comb begin
    db_level_next = db_level_reg;
    db_count_next = db_count_reg;
    if (btn_sync_reg != db_level_reg) begin
      if (db_count_reg == DB_LAST) begin
        db_level_next = btn_sync_reg;
        db_count_next = '0;
      end else begin
        db_count_next = db_count_reg + 1'b1;
      end
    end else begin
      db_count_next = '0;
    end
  end

  always_ff @(posedge CLOCK_100) begin
    if (rst) begin
      db_level_reg    <= 1'b0;
      db_count_reg    <= '0;
      start_pulse_reg <= 1'b0;
    end else begin
      db_level_reg    <= db_level_next;
      db_count_reg    <= db_count_next;
      // High for exactly the cycle following an accepted 0->1 change.
      start_pulse_reg <= db_level_next & ~db_level_reg;
    end
  end

  // -------------------------------------------------------------------------
  // Test FSM and datapath
  // -------------------------------------------------------------------------
  logic [2:0]  state_reg,     state_next;
  logic [7:0]  seed_reg,      seed_next;
  logic [7:0]  index_reg,     index_next;
  logic [5:0]  err_count_reg, err_count_next;
  logic        pass_reg,      pass_next;
  logic        fail_reg,      fail_next;
  logic        cmd_valid_reg, cmd_valid_next;
  logic        cmd_we_reg,    cmd_we_next;
  logic [23:0] cmd_addr_reg,  cmd_addr_next;
  logic [15:0] cmd_wdata_reg, cmd_wdata_next;

  logic [15:0] expected_word;
  logic [23:0] word_addr;
  logic        rd_mismatch;
  logic [5:0]  err_bumped;

  always_comb begin
    expected_word = {seed_reg, index_reg};
    word_addr     = BASE_ADDR + {16'd0, index_reg};
    rd_mismatch   = (rd_data != expected_word);
    err_bumped    = (rd_mismatch && (err_count_reg != ERR_MAX)) ?
                    err_count_reg + 6'd1 : err_count_reg;
  end

  always_comb begin
    state_next     = state_reg;
    seed_next      = seed_reg;
    index_next     = index_reg;
    err_count_next = err_count_reg;
    pass_next      = pass_reg;
    fail_next      = fail_reg;
    cmd_valid_next = cmd_valid_reg;
    cmd_we_next    = cmd_we_reg;
    cmd_addr_next  = cmd_addr_reg;
    cmd_wdata_next = cmd_wdata_reg;

    case (state_reg)
      S_IDLE: begin
        cmd_valid_next = 1'b0;
        if (start_pulse_reg) begin
          seed_next      = seed_reg + 8'd1;
          index_next     = 8'd0;
          err_count_next = 6'd0;
          pass_next      = 1'b0;
          fail_next      = 1'b0;
          state_next     = S_WRITE;
        end
      end

      // A command is presented one cycle after its index is known and held
      // until accepted; valid then drops for a cycle before the next one.
      S_WRITE: begin
        if (!cmd_valid_reg) begin
          cmd_valid_next = 1'b1;
          cmd_we_next    = 1'b1;
          cmd_addr_next  = word_addr;
          cmd_wdata_next = expected_word;
        end else if (cmd_ready) begin
          cmd_valid_next = 1'b0;
          if (index_reg == LAST_INDEX) begin
            index_next = 8'd0;
            state_next = S_READ;
          end else begin
            index_next = index_reg + 8'd1;
          end
        end
      end

      S_READ: begin
        if (!cmd_valid_reg) begin
          cmd_valid_next = 1'b1;
          cmd_we_next    = 1'b0;
          cmd_addr_next  = word_addr;
          cmd_wdata_next = 16'h0000;
        end else if (cmd_ready) begin
          cmd_valid_next = 1'b0;
          state_next     = S_WAIT_RD;
        end
      end

      // Only one read is ever outstanding, so the first rd_valid seen here
      // belongs to the current index.
      S_WAIT_RD: begin
        cmd_valid_next = 1'b0;
        if (rd_valid) begin
          err_count_next = err_bumped;
          if (index_reg == LAST_INDEX) begin
            pass_next  = (err_bumped == 6'd0);
            fail_next  = (err_bumped != 6'd0);
            state_next = S_DONE;
          end else begin
            index_next = index_reg + 8'd1;
            state_next = S_READ;
          end
        end
      end

      S_DONE: begin
        cmd_valid_next = 1'b0;
        state_next     = S_IDLE;
      end

      default: begin
        cmd_valid_next = 1'b0;
        state_next     = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK_100) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      seed_reg      <= 8'd0;
      index_reg     <= 8'd0;
      err_count_reg <= 6'd0;
      pass_reg      <= 1'b0;
      fail_reg      <= 1'b0;
      cmd_valid_reg <= 1'b0;
      cmd_we_reg    <= 1'b0;
      cmd_addr_reg  <= 24'd0;
      cmd_wdata_reg <= 16'd0;
    end else begin
      state_reg     <= state_next;
      seed_reg      <= seed_next;
      index_reg     <= index_next;
      err_count_reg <= err_count_next;
      pass_reg      <= pass_next;
      fail_reg      <= fail_next;
      cmd_valid_reg <= cmd_valid_next;
      cmd_we_reg    <= cmd_we_next;
      cmd_addr_reg  <= cmd_addr_next;
      cmd_wdata_reg <= cmd_wdata_next;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign cmd_valid = cmd_valid_reg;
  assign cmd_we    = cmd_we_reg;
  assign cmd_addr  = cmd_addr_reg;
  assign cmd_wdata = cmd_wdata_reg;
  assign busy      = (state_reg == S_WRITE) || (state_reg == S_READ) ||
                     (state_reg == S_WAIT_RD);
  assign led       = {pass_reg, fail_reg, err_count_reg};

endmodule

// File: doc/sdram_test_sequencer.md
SDRAM_TEST_SEQUENCER -- requirements
Module: sdram_test_sequencer

Interface
REQ-001 SHALL have parameter N_WORDS, default 16, number of words written then read per run (1..256).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 4, number of consecutive stable synchronized samples required to accept a button level change.
REQ-003 SHALL have parameter BASE_ADDR, default 24'h000000, first word address of each run.
REQ-004 CLOCK_100  in  1  sole clock; all logic on its rising edge.
REQ-005 rst  in  1  synchronous reset, active-high.
REQ-006 button  in  1  raw asynchronous push-button, active-high.
REQ-007 cmd_valid  out  1  command request to the SDRAM driver.
REQ-008 cmd_we  out  1  1 = write, 0 = read.
REQ-009 cmd_addr  out  24  word address.
REQ-010 cmd_wdata  out  16  write data.
REQ-011 cmd_ready  in  1  driver accepts the command this cycle.
REQ-012 rd_valid  in  1  read data present this cycle.
REQ-013 rd_data  in  16  read data.
REQ-014 busy  out  1  high while a run is in progress.
REQ-015 led  out  8  {pass, fail, err_count[5:0]}.

Function
REQ-016 button SHALL pass through a 2-flop synchronizer before any other use.
REQ-017 Debounced level SHALL change only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles; any intervening match SHALL restart the count.
REQ-018 A 0->1 transition of the debounced level SHALL produce a one-cycle start pulse.
REQ-019 FSM states: IDLE, WRITE, READ, WAIT_RD, DONE; DONE returns to IDLE in one cycle.
REQ-020 Start pulse in IDLE SHALL: increment 8-bit seed (wrapping 255->0), clear index and err_count, clear pass/fail, enter WRITE; start pulse in any other state SHALL be ignored.
REQ-021 Write pattern for index i SHALL be {seed, i[7:0]}; cmd_addr = BASE_ADDR + i (mod 2^24).
REQ-022 cmd_valid SHALL assert the cycle after entering WRITE or READ and SHALL stay high, with cmd_we/cmd_addr/cmd_wdata stable, until a cycle where cmd_ready = 1 (handshake).
REQ-023 WRITE: on each handshake increment index; after handshake of index N_WORDS-1 reset index to 0 and enter READ, with cmd_valid low for at least that one cycle.
REQ-024 READ: issue read of address BASE_ADDR + index (cmd_we = 0, cmd_wdata = 0); on handshake enter WAIT_RD; at most one read outstanding.
REQ-025 WAIT_RD: on rd_valid compare rd_data to {seed, index[7:0]}; mismatch increments err_count, saturating at 63; then index+1 and READ, or DONE after index N_WORDS-1.
REQ-026 rd_valid in the same cycle as the READ handshake SHALL be ignored; rd_valid outside WAIT_RD SHALL be ignored.
REQ-027 On entering DONE: pass = (err_count == 0), fail = ~pass; led holds these values and err_count until the next start pulse.
REQ-028 busy SHALL be high in WRITE, READ, WAIT_RD, low in IDLE and DONE.
REQ-029 cmd_valid SHALL never assert in IDLE, WAIT_RD or DONE.

Reset
REQ-030 While rst = 1 at a clock edge: state IDLE, cmd_valid 0, cmd_we 0, cmd_addr 0, cmd_wdata 0, busy 0, led 8'h00, seed 0, index 0, err_count 0, synchronizer and debounce state 0.
REQ-031 rst asserted mid-run SHALL abort the run with no further commands issued; an accepted-but-unreturned read is discarded.

Verification (N_WORDS=4, DEBOUNCE_CYCLES=4, BASE_ADDR=0; memory model echoes written data, rd_valid 3 cycles after read handshake)
REQ-032 Reset: rst high 3 cycles -> all outputs 0, led = 8'h00.
REQ-033 Glitch: button high 2 cycles -> no start, cmd_valid stays 0, busy 0.
REQ-034 Clean run: button high 20 cycles, cmd_ready always 1 -> writes addr 0..3 data 16'h0100..16'h0103, reads addr 0..3, led = 8'h80, busy low; second press -> data 16'h0200..16'h0203, led = 8'h80.
REQ-035 Error: model returns 16'h0000 for address 2 -> led = 8'h41; all 4 words wrong -> led = 8'h44.
REQ-036 Backpressure: cmd_ready low 10 cycles during write of addr 1 -> cmd_valid high, cmd_addr = 1, cmd_wdata = 16'h0101 stable for all 10 cycles; exactly one write per address.
REQ-037 Reset mid-run: rst during WAIT_RD -> next cycle cmd_valid 0, busy 0, led 8'h00; next press uses seed 1 (data 16'h0100..).
